// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator display path.
// Widths, limits and FSM state encoding for the BCD converter.
package calc_pkg;

   localparam int W_DATA   = 28;
   localparam int N_DIGITS = 8;
   localparam int W_BCD    = 4 * N_DIGITS;
   localparam int W_CNT    = $clog2(W_DATA + 1);

   localparam logic [W_DATA-1:0] MAX_DISP  = 28'd99_999_999;
   localparam logic [W_BCD-1:0]  ERR_BCD   = '1;
   localparam logic [W_CNT-1:0]  LAST_STEP = W_CNT'(W_DATA - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/dd_digit_adj.sv
// Double-dabble digit correction.
// Adds 3 to a BCD digit of 5 or more so the next shift carries correctly.
module dd_digit_adj (
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);

   // add-3-if-at-least-5
   always_comb begin
      d_o = d_i;
      if (d_i >= 4'd5) begin
         d_o = d_i + 4'd3;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential signed binary to packed BCD converter.
// One double-dabble step per clock; fixed 29-edge latency.
module bin_to_bcd_seq
   import calc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [W_DATA-1:0]     d_in,
   input  logic                  ovr_in,
   input  logic                  valid_in,
   output logic                  busy,
   output logic [4*N_DIGITS-1:0] bcd,
   output logic [N_DIGITS-1:0]   digit_en,
   output logic                  neg,
   output logic                  err,
   output logic                  valid_out
);

   state_t              state_q, state_d;
   logic [W_DATA-1:0]   mag_q, mag_d;
   logic [W_BCD-1:0]    scr_q, scr_d;
   logic [W_CNT-1:0]    cnt_q, cnt_d;
   logic                sign_q, sign_d;
   logic                bad_q, bad_d;
   logic [W_BCD-1:0]    bcd_q, bcd_d;
   logic [N_DIGITS-1:0] den_q, den_d;
   logic                neg_q, neg_d;
   logic                err_q, err_d;
   logic                vo_q, vo_d;

   logic [W_BCD-1:0]    scr_adj;
   logic [W_DATA-1:0]   mag_in;
   logic [N_DIGITS-1:0] den_calc;

   genvar g;
   generate
      for (g = 0; g < N_DIGITS; g++) begin : g_adj
         dd_digit_adj u_adj (
            .d_i (scr_q[4*g +: 4]),
            .d_o (scr_adj[4*g +: 4])
         );
      end
   endgenerate

   // magnitude of the incoming operand; -2^27 maps to 2^27 unsigned
   always_comb begin
      mag_in = d_in;
      if (d_in[W_DATA-1]) begin
         mag_in = ~d_in + W_DATA'(1);
      end
   end

   // leading-zero blanking: a digit shows if it or any higher one is nonzero
   always_comb begin
      logic any_nz;
      any_nz   = 1'b0;
      den_calc = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         any_nz      = any_nz | (scr_q[4*i +: 4] != 4'd0);
         den_calc[i] = any_nz;
      end
      den_calc[0] = 1'b1;
   end

   // next-state and datapath control
   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      bad_d   = bad_q;
      bcd_d   = bcd_q;
      den_d   = den_q;
      neg_d   = neg_q;
      err_d   = err_q;
      vo_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid_in) begin
               mag_d   = mag_in;
               sign_d  = d_in[W_DATA-1];
               bad_d   = ovr_in | (mag_in > MAX_DISP);
               scr_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {scr_d, mag_d} = {scr_adj[W_BCD-2:0], mag_q, 1'b0};
            cnt_d = cnt_q + W_CNT'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bad_q) begin
               bcd_d = ERR_BCD;
               den_d = '1;
               neg_d = 1'b0;
               err_d = 1'b1;
            end else begin
               bcd_d = scr_q;
               den_d = den_calc;
               neg_d = sign_q;
               err_d = 1'b0;
            end
            vo_d    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mag_q   <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         bad_q   <= 1'b0;
         bcd_q   <= '0;
         den_q   <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
         vo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         bad_q   <= bad_d;
         bcd_q   <= bcd_d;
         den_q   <= den_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
         vo_q    <= vo_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign bcd       = bcd_q;
   assign digit_en  = den_q;
   assign neg       = neg_q;
   assign err       = err_q;
   assign valid_out = vo_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq.
// Hand-computed BCD vectors, latency, drop and reset checks.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst;
   logic [27:0] d_in;
   logic        ovr_in;
   logic        valid_in;
   logic        busy;
   logic [31:0] bcd;
   logic [7:0]  digit_en;
   logic        neg;
   logic        err;
   logic        valid_out;

   int total;
   int bad;

   bin_to_bcd_seq dut (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in),
      .ovr_in    (ovr_in),
      .valid_in  (valid_in),
      .busy      (busy),
      .bcd       (bcd),
      .digit_en  (digit_en),
      .neg       (neg),
      .err       (err),
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Entered and left at posedge+1.
   task automatic run_op(input string tag,
                         input logic [27:0] d,
                         input logic ovr,
                         input logic [31:0] eb,
                         input logic [7:0] ee,
                         input logic en,
                         input logic er);
      int n;
      int bc;
      d_in     = d;
      ovr_in   = ovr;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      n  = 0;
      bc = busy ? 1 : 0;
      while (!valid_out && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (!valid_out && busy) bc++;
      end
      chk({tag, "_lat"}, n, 29);
      chk({tag, "_busycyc"}, bc, 29);
      chk({tag, "_busy0"}, {31'd0, busy}, 0);
      chk({tag, "_bcd"}, bcd, eb);
      chk({tag, "_den"}, {24'd0, digit_en}, {24'd0, ee});
      chk({tag, "_neg"}, {31'd0, neg}, {31'd0, en});
      chk({tag, "_err"}, {31'd0, err}, {31'd0, er});
      @(posedge clk);
      #1;
      chk({tag, "_vo1cyc"}, {31'd0, valid_out}, 0);
   endtask

   initial begin
      int n;
      int vc;
      int lat;
      logic [31:0] first_bcd;
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      d_in     = '0;
      ovr_in   = 1'b0;
      valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bcd", bcd, 0);
      chk("rst_den", {24'd0, digit_en}, 0);
      chk("rst_flags", {27'd0, busy, neg, err, valid_out, 1'b0}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("d120", 28'd120, 1'b0, 32'h00000120, 8'h07, 1'b0, 1'b0);
      run_op("dmax", 28'd99_999_999, 1'b0, 32'h99999999, 8'hFF, 1'b0, 1'b0);
      run_op("dnmax", -28'sd99_999_999, 1'b0, 32'h99999999, 8'hFF, 1'b1, 1'b0);
      run_op("d1000", 28'd1000, 1'b0, 32'h00001000, 8'h0F, 1'b0, 1'b0);
      run_op("drange", 28'd100_000_000, 1'b0, 32'hFFFFFFFF, 8'hFF, 1'b0, 1'b1);
      run_op("dovr", 28'h0FFFFFFF, 1'b1, 32'hFFFFFFFF, 8'hFF, 1'b0, 1'b1);
      run_op("dmin", 28'h8000000, 1'b0, 32'hFFFFFFFF, 8'hFF, 1'b0, 1'b1);
      run_op("dm45", -28'sd45, 1'b0, 32'h00000045, 8'h03, 1'b1, 1'b0);
      run_op("dzero", 28'd0, 1'b0, 32'h00000000, 8'h01, 1'b0, 1'b0);
      run_op("d120b", 28'd120, 1'b0, 32'h00000120, 8'h07, 1'b0, 1'b0);

      // dropped operand while busy
      d_in     = 28'd7;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      d_in     = 28'd9;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in  = 1'b0;
      vc        = 0;
      lat       = 0;
      first_bcd = '0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (valid_out) begin
            if (vc == 0) begin
               first_bcd = bcd;
               lat       = 7 + i;
            end
            vc++;
         end
      end
      chk("drop_cnt", vc, 1);
      chk("drop_bcd", first_bcd, 32'h7);
      chk("drop_lat", lat, 29);

      // reset in the middle of a conversion
      d_in     = 28'd321;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_bcd", bcd, 0);
      chk("mrst_den", {24'd0, digit_en}, 0);
      chk("mrst_flags", {27'd0, busy, neg, err, valid_out, 1'b0}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      vc  = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (valid_out) vc++;
      end
      chk("mrst_novo", vc, 0);
      run_op("post_rst", 28'd4567, 1'b0, 32'h00004567, 8'h0F, 1'b0, 1'b0);

      // back-to-back: E29 request ignored, E30 request accepted
      d_in     = 28'd5;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (28) @(posedge clk);
      #1;
      chk("b2b_busy28", {31'd0, busy}, 1);
      d_in     = 28'd3;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_vo", {31'd0, valid_out}, 1);
      chk("b2b_bcd5", bcd, 32'h5);
      chk("b2b_idle", {31'd0, busy}, 0);
      d_in = 28'd6;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      chk("b2b_acc", {31'd0, busy}, 1);
      n = 0;
      while (!valid_out && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("b2b_lat", n, 29);
      chk("b2b_bcd6", bcd, 32'h6);
      vc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (valid_out) vc++;
      end
      chk("b2b_novo", vc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Downstream stage of the calculator's arithmetic units, factorial included. Takes a 28-bit signed two's-complement result plus an overflow flag and converts it to 8 packed BCD digits for the 7-segment display driver.
- Uses a sequential double-dabble: one shift-add-3 step per clock.
- Also flags sign, error/overflow and leading-zero blanking.

Parameters:
- W_DATA, 28, input word width including the sign bit.
- N_DIGITS, 8, number of BCD output digits.
- MAX_DISP, 99_999_999, largest displayable magnitude.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- d_in  in  W_DATA  signed operand from the arithmetic stage.
- ovr_in  in  1  upstream overflow flag, qualified by valid_in.
- valid_in  in  1  single-cycle strobe: d_in/ovr_in are valid.
- busy  out  1  conversion in progress; valid_in is ignored while high.
- bcd  out  4*N_DIGITS  packed BCD, digit 0 in bits [3:0].
- digit_en  out  N_DIGITS  per-digit enable with leading zeros blanked.
- neg  out  1  result is negative.
- err  out  1  overflow or out-of-range result.
- valid_out  out  1  one-cycle strobe: bcd/digit_en/neg/err are updated.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all outputs 0 (bcd, digit_en, neg, err, busy, valid_out).
  - Shift/scratch registers and counter cleared.
  - Reset mid-conversion aborts it; no valid_out is produced for that operand.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - On edge E0 with valid_in=1, capture mag = |d_in| as W_DATA-bit unsigned; -2^27 gives 2^27.
  - Capture sign = d_in[W_DATA-1].
  - Capture bad = ovr_in OR (mag > MAX_DISP).
  - Clear the BCD scratch register; cnt=0; go to SHIFT; busy=1.
- SHIFT:
  - Each edge: add 3 to every scratch digit >= 5, then shift {scratch,mag} left by one; cnt++.
  - After W_DATA steps (edges E1..E28), go to DONE.
  - This path runs for the bad case too, so latency is fixed.
- DONE, edge E29:
  - Register outputs.
  - If bad: bcd = all ones (0xFFFFFFFF), digit_en = all ones, neg=0, err=1.
  - Else: bcd = scratch, neg = sign, err=0, and digit_en[i]=1 iff digit i is nonzero or any higher digit is nonzero; digit_en[0] is always 1.
  - valid_out=1 for exactly one cycle; busy=0; return to IDLE.
- Latency and throughput:
  - valid_out is visible in the cycle after E29, i.e. fixed latency 29 edges from the sampling edge.
  - Next accept is possible at E30, so throughput is one operand per 30 cycles.
- valid_in handling:
  - Ignored in SHIFT and DONE (busy=1 or DONE); dropped, not queued.
  - Upstream must wait for busy=0.
- bcd, digit_en, neg and err hold their values until the next DONE; they do not change during a conversion.
- Zero: bcd=0, digit_en=0x01, neg=0. No negative zero is possible.
- Arithmetic:
  - The scratch register is 4*N_DIGITS bits.
  - The add-3 correction is applied before each shift, never after the final shift.

Decomposition:
- Package calc_pkg:
  - W_DATA=28, N_DIGITS=8, MAX_DISP=99_999_999.
  - ERR_BCD = all-ones constant.
  - State enum {IDLE, SHIFT, DONE}.
  - Counter width = $clog2(W_DATA+1).
- One combinational sub-module, dd_digit_adj: a 4-bit in/out add-3-if-≥5 correction, instantiated N_DIGITS times via generate.

Test Plan:
- d_in=120, valid_in pulse → valid_out exactly 29 edges later; bcd=0x00000120, digit_en=0x07, neg=0, err=0; busy high for those 29 cycles.
- d_in=99_999_999 → bcd=0x99999999, digit_en=0xFF, err=0.
- d_in=100_000_000 → err=1, bcd=0xFFFFFFFF.
- d_in=0x0FFFFFFF with ovr_in=1 → err=1, bcd=0xFFFFFFFF.
- d_in=0x8000000 (-2^27) → err=1, neg=0.
- d_in=-45 → bcd=0x00000045, digit_en=0x03, neg=1.
- d_in=0 → bcd=0, digit_en=0x01.
- Dropped operand: d_in=7 accepted, then valid_in with d_in=9 five cycles later → exactly one valid_out, bcd=0x7; the second operand is dropped.
- Reset mid-conversion: assert rst 10 cycles into a conversion → no valid_out; all outputs 0 immediately.
- Next conversion after reset works normally.
- Back-to-back: second valid_in at E30 is accepted; a second valid_in at E29 is ignored.
